// File: rtl/muldiv_sched_if.sv
// EX-stage multiply/divide handshake bundle between the pipeline and muldiv_sched.
// Pipeline -> unit: start, op, a, b, cpu_stall, flush.
// Unit -> pipeline: mult_div_stall, mult_div_over, hi, lo (architectural HI/LO).
interface muldiv_sched_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cpu_stall;
  logic        flush;
  logic        mult_div_stall;
  logic        mult_div_over;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cpu_stall, flush,
    input  mult_div_stall, mult_div_over, hi, lo
  );

  modport slave (
    input  start, op, a, b, cpu_stall, flush,
    output mult_div_stall, mult_div_over, hi, lo
  );
endinterface

// File: rtl/muldiv_sched.sv
// Sequencer plus radix-2 engine for MULT/MULTU/DIV/DIVU with the HI/LO registers.
// Latency: 32 iterations (1 for multiply when MUL_FAST); over pulses the cycle after the HI/LO write.
// Backpressure: mult_div_stall freezes EX while busy; cpu_stall holds every register; flush cancels.
// Ports: clk, reset (async, active-high), md (slave side of muldiv_sched_if):
//   start/op/a/b in, cpu_stall/flush in, mult_div_stall/mult_div_over/hi/lo out.
module muldiv_sched #(
  parameter bit          MUL_FAST   = 1'b0,
  parameter logic [31:0] ZERO_DIV_Q = 32'hFFFFFFFF
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_sched_if.slave  md
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;      // multiply partial product
  logic [63:0] mcand;    // |a|; shifts left per multiply step, low half stays |a| during divide
  logic [31:0] shreg;    // multiply: |b| shifting right; divide: dividend out, quotient in
  logic [31:0] dsor;     // |b| for divide
  logic [31:0] rem;      // partial remainder
  logic        a_neg;    // dividend sign, drives remainder sign
  logic        res_neg;  // product / quotient sign
  logic        b_zero;
  logic [31:0] hi_q, lo_q;

  logic        is_signed, last_iter, advance, q_bit;
  logic [31:0] a_abs, b_abs;
  logic [63:0] mul_sum, fast_prod, prod, prod_fix;
  logic [32:0] trial;
  logic [31:0] rem_nx, quo_nx, quo_fix, rem_fix, a_orig;

  // Operand magnitudes; unsigned ops pass straight through
  assign is_signed = ~md.op[0];
  assign a_abs     = (is_signed && md.a[31]) ? (~md.a + 32'd1) : md.a;
  assign b_abs     = (is_signed && md.b[31]) ? (~md.b + 32'd1) : md.b;

  // Shift-add step; fast mode multiplies the latched magnitudes outright
  assign mul_sum   = acc + (shreg[0] ? mcand : 64'd0);
  assign fast_prod = {32'd0, mcand[31:0]} * {32'd0, shreg};
  assign prod      = MUL_FAST ? fast_prod : mul_sum;
  assign prod_fix  = res_neg ? (~prod + 64'd1) : prod;

  // Restoring step: bit 32 of the 33-bit difference set means the trial went negative
  assign trial   = {rem, shreg[31]} - {1'b0, dsor};
  assign q_bit   = ~trial[32];
  assign rem_nx  = q_bit ? trial[31:0] : {rem[30:0], shreg[31]};
  assign quo_nx  = {shreg[30:0], q_bit};
  assign quo_fix = res_neg ? (~quo_nx + 32'd1) : quo_nx;
  assign rem_fix = a_neg ? (~rem_nx + 32'd1) : rem_nx;
  assign a_orig  = a_neg ? (~mcand[31:0] + 32'd1) : mcand[31:0];

  assign last_iter = (cnt == 5'd31) || ((state == MUL) && MUL_FAST);
  assign advance   = ~md.flush & ~md.cpu_stall;

  assign md.hi = hi_q;
  assign md.lo = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    md.mult_div_stall = 1'b0;
    md.mult_div_over  = 1'b0;
    case (state)
      IDLE: begin
        md.mult_div_stall = md.start & ~md.flush;
        if (md.start) state_nx = md.op[1] ? DIV : MUL;
      end
      MUL, DIV: begin
        md.mult_div_stall = 1'b1;
        if (last_iter) state_nx = DONE;
      end
      DONE: begin
        // A flushed instruction must not see its completion
        md.mult_div_over = ~md.flush;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (md.flush)          state_nx = IDLE;
    else if (md.cpu_stall) state_nx = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 5'd0;
      acc     <= 64'd0;
      mcand   <= 64'd0;
      shreg   <= 32'd0;
      dsor    <= 32'd0;
      rem     <= 32'd0;
      a_neg   <= 1'b0;
      res_neg <= 1'b0;
      b_zero  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (advance) begin
      case (state)
        IDLE: if (md.start) begin
          cnt     <= 5'd0;
          acc     <= 64'd0;
          mcand   <= {32'd0, a_abs};
          shreg   <= md.op[1] ? a_abs : b_abs;
          dsor    <= b_abs;
          rem     <= 32'd0;
          a_neg   <= is_signed & md.a[31];
          res_neg <= is_signed & (md.a[31] ^ md.b[31]);
          b_zero  <= (md.b == 32'd0);
        end
        MUL: begin
          acc   <= mul_sum;
          mcand <= mcand << 1;
          shreg <= shreg >> 1;
          cnt   <= cnt + 5'd1;
          if (last_iter) {hi_q, lo_q} <= prod_fix;
        end
        DIV: begin
          rem   <= rem_nx;
          shreg <= quo_nx;
          cnt   <= cnt + 5'd1;
          if (last_iter) begin
            if (b_zero) begin
              hi_q <= a_orig;
              lo_q <= ZERO_DIV_Q;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: two instances (MUL_FAST 0 and 1) share one stimulus stream.
// A cycle-level behavioural model (countdown + arithmetic result) is compared every cycle;
// directed cases pin latency and literal HI/LO values, then a randomized phase follows.
module tb_muldiv_sched;
  localparam logic [31:0] ZQ = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cpu_stall, flush;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model state per instance
  int          m_busy [2];
  bit          m_done [2];
  logic [31:0] m_hi [2], m_lo [2], m_phi [2], m_plo [2];
  bit          s_over [2];
  int          over_cnt [2];

  muldiv_sched_if if0();
  muldiv_sched_if if1();

  assign if0.start = start;  assign if1.start = start;
  assign if0.op = op;        assign if1.op = op;
  assign if0.a = a;          assign if1.a = a;
  assign if0.b = b;          assign if1.b = b;
  assign if0.cpu_stall = cpu_stall;  assign if1.cpu_stall = cpu_stall;
  assign if0.flush = flush;  assign if1.flush = flush;

  muldiv_sched #(.MUL_FAST(1'b0)) dut0 (.clk(clk), .reset(reset), .md(if0));
  muldiv_sched #(.MUL_FAST(1'b1)) dut1 (.clk(clk), .reset(reset), .md(if1));

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result from the instruction definition
  function automatic void calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = 32'd0;
    l = 32'd0;
    case (o)
      2'b00: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          h = x;
          l = ZQ;
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          l = 32'(q);
          h = 32'(r);
        end else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  task automatic model_cycle(input int i);
    logic st, ov;
    logic [31:0] h, l;
    logic [31:0] ph, pl;
    bit idle;
    if (i == 0) begin st = if0.mult_div_stall; ov = if0.mult_div_over; h = if0.hi; l = if0.lo; end
    else        begin st = if1.mult_div_stall; ov = if1.mult_div_over; h = if1.hi; l = if1.lo; end
    if (reset) begin
      m_busy[i] = 0; m_done[i] = 0; m_hi[i] = 32'd0; m_lo[i] = 32'd0;
    end
    idle = (m_busy[i] == 0) && !m_done[i];
    check32($sformatf("stall%0d", i), {31'd0, st},
            {31'd0, (m_busy[i] > 0) || (idle && start && !flush)});
    check32($sformatf("over%0d", i), {31'd0, ov}, {31'd0, m_done[i] && !flush});
    check32($sformatf("hi%0d", i), h, m_hi[i]);
    check32($sformatf("lo%0d", i), l, m_lo[i]);
    s_over[i] = ov;
    if (ov) over_cnt[i]++;
    if (!reset) begin
      if (flush) begin
        m_busy[i] = 0;
        m_done[i] = 0;
      end else if (!cpu_stall) begin
        if (m_busy[i] > 0) begin
          m_busy[i]--;
          if (m_busy[i] == 0) begin
            m_hi[i] = m_phi[i];
            m_lo[i] = m_plo[i];
            m_done[i] = 1;
          end
        end else if (m_done[i]) begin
          m_done[i] = 0;
        end else if (start) begin
          calc(op, a, b, ph, pl);
          m_phi[i] = ph;
          m_plo[i] = pl;
          m_busy[i] = (i == 1 && !op[1]) ? 1 : 32;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    start = 1'b0; cpu_stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Issue one op, hold start until the watched instance completes (or flush_at passes)
  task automatic run_op(input int which, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int stall_at, input int stall_len,
                        input int flush_at, output int lat);
    int t0;
    lat = -1;
    start = 1'b1; op = o; a = x; b = y;
    t0 = cyc;
    for (int n = 0; n < 100; n++) begin
      cpu_stall = (stall_len > 0) && (cyc - t0 >= stall_at) && (cyc - t0 < stall_at + stall_len);
      flush = (cyc - t0 == flush_at);
      step();
      if (flush_at >= 0 && cyc - t0 > flush_at) break;
      if (s_over[which]) begin
        lat = cyc - 1 - t0;
        break;
      end
    end
    start = 1'b0; cpu_stall = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, oc;
    logic [31:0] h, l;

    // pin the model against hand-computed results
    calc(2'b00, 32'hFFFFFFFE, 32'd7, h, l);
    check32("pin_mult_hi", h, 32'hFFFFFFFF);  check32("pin_mult_lo", l, 32'hFFFFFFF2);
    calc(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l);
    check32("pin_multu_hi", h, 32'hFFFFFFFE); check32("pin_multu_lo", l, 32'h00000001);
    calc(2'b10, 32'hFFFFFFF9, 32'd2, h, l);
    check32("pin_div_hi", h, 32'hFFFFFFFF);   check32("pin_div_lo", l, 32'hFFFFFFFD);
    calc(2'b11, 32'd100, 32'd7, h, l);
    check32("pin_divu_hi", h, 32'd2);         check32("pin_divu_lo", l, 32'd14);
    calc(2'b11, 32'd5, 32'd0, h, l);
    check32("pin_dz_hi", h, 32'd5);           check32("pin_dz_lo", l, 32'hFFFFFFFF);
    calc(2'b10, 32'h80000000, 32'hFFFFFFFF, h, l);
    check32("pin_ovf_hi", h, 32'd0);          check32("pin_ovf_lo", l, 32'h80000000);

    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
      m_phi[i] = 0; m_plo[i] = 0; s_over[i] = 0; over_cnt[i] = 0;
    end

    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    cpu_stall = 1'b0; flush = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) step();
    start = 1'b1;
    step();  // stall follows start during reset
    start = 1'b0;
    reset = 1'b0;
    step();
    check32("rst_hi", if0.hi, 32'd0);
    check32("rst_lo", if0.lo, 32'd0);

    run_op(0, 2'b00, 32'hFFFFFFFE, 32'd7, 0, 0, -1, lat);
    check32("mult_lat", lat, 33);
    check32("mult_hi", if0.hi, 32'hFFFFFFFF); check32("mult_lo", if0.lo, 32'hFFFFFFF2);
    idle_steps(3);

    run_op(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, -1, lat);
    check32("fast_lat", lat, 2);
    check32("fast_hi", if1.hi, 32'hFFFFFFFE); check32("fast_lo", if1.lo, 32'h00000001);
    idle_steps(40);
    check32("multu_hi", if0.hi, 32'hFFFFFFFE); check32("multu_lo", if0.lo, 32'h00000001);

    run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, -1, lat);
    check32("div_lat", lat, 33);
    check32("div_hi", if0.hi, 32'hFFFFFFFF); check32("div_lo", if0.lo, 32'hFFFFFFFD);
    run_op(0, 2'b11, 32'd5, 32'd0, 0, 0, -1, lat);
    check32("dz_lat", lat, 33);
    check32("dz_hi", if0.hi, 32'd5); check32("dz_lo", if0.lo, 32'hFFFFFFFF);
    run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, -1, lat);
    check32("ovf_hi", if0.hi, 32'd0); check32("ovf_lo", if0.lo, 32'h80000000);

    run_op(0, 2'b11, 32'd100, 32'd7, 10, 3, -1, lat);
    check32("stall_lat", lat, 36);
    check32("divu_hi", if0.hi, 32'd2); check32("divu_lo", if0.lo, 32'd14);

    oc = over_cnt[0];
    run_op(0, 2'b11, 32'd100, 32'd7, 0, 0, -1, lat);
    idle_steps(40);
    check32("single_pulse", over_cnt[0] - oc, 1);

    oc = over_cnt[0];
    run_op(0, 2'b00, 32'd3, 32'd5, 0, 0, 10, lat);
    idle_steps(40);
    check32("flush10_pulses", over_cnt[0] - oc, 0);
    check32("flush10_hi", if0.hi, 32'd2); check32("flush10_lo", if0.lo, 32'd14);

    oc = over_cnt[0];
    run_op(0, 2'b11, 32'd9, 32'd2, 0, 0, 32, lat);
    idle_steps(40);
    check32("flush32_pulses", over_cnt[0] - oc, 0);
    check32("flush32_hi", if0.hi, 32'd2); check32("flush32_lo", if0.lo, 32'd14);

    oc = over_cnt[0];
    run_op(0, 2'b01, 32'd3, 32'd5, 0, 0, 33, lat);
    idle_steps(40);
    check32("flush33_pulses", over_cnt[0] - oc, 0);
    check32("flush33_hi", if0.hi, 32'd0); check32("flush33_lo", if0.lo, 32'd15);

    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    check32("rstmid_hi", if0.hi, 32'd0); check32("rstmid_lo", if0.lo, 32'd0);
    reset = 1'b0; start = 1'b0;
    step();
    check32("rstmid_stall", {31'd0, if0.mult_div_stall}, 32'd0);

    for (int k = 0; k < 4000; k++) begin
      start     = ($urandom_range(0, 2) != 0);
      op        = 2'($urandom_range(0, 3));
      a         = pick();
      b         = pick();
      cpu_stall = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      reset     = ($urandom_range(0, 699) == 0);
      step();
    end
    reset = 1'b0;
    idle_steps(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencing controller plus iterative engine for MULT/MULTU/DIV/DIVU issued from EX.
- Produces the mult_div_stall / mult_div_over pair consumed by the pipeline flow controller, and owns the architectural HI/LO result registers written by those instructions.
- Both operations are radix-2 and take 32 iterations. A parameter gives a single-iteration multiply.

Parameters:
- MUL_FAST, 0: 1 = multiply finishes in one iteration cycle; 0 = 32-iteration shift-add.
- ZERO_DIV_Q, 32'hFFFFFFFF: quotient (LO) written on divide by zero.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  EX holds a mul/div instruction; level, held until the pipeline advances
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand / dividend
- b  in  32  rt operand / divisor
- cpu_stall  in  1  global freeze
- flush  in  1  cancel the in-flight operation (exception/redirect)
- mult_div_stall  out  1  request to freeze the pipeline
- mult_div_over  out  1  one-cycle result-ready pulse
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: clock clk; reset reset is asynchronous, active-high.
- Reset values: state=IDLE, cnt=0, hi=0, lo=0, all internal accumulators=0. Consequently mult_div_over=0, and mult_div_stall follows start.
- States:
  - IDLE: accepting a new operation.
  - MUL: multiply iterations in progress.
  - DIV: divide iterations in progress.
  - DONE: result held; mult_div_over asserted for one cycle.
- Priority at each edge: reset > flush > cpu_stall > normal.
  - flush: next state IDLE; hi/lo unchanged; no over pulse.
  - cpu_stall: every register holds.
- IDLE with start=1:
  - Latch |a|, |b|, the sign of a, and the sign of the product/quotient. Signs are taken from a[31]/b[31] only for MULT/DIV; MULTU/DIVU are unsigned.
  - cnt<=0; go to MUL or DIV.
- MUL/DIV: one iteration per unstalled cycle.
  - Multiply: shift-add of a 64-bit accumulator.
  - Divide: restoring; one quotient bit per cycle; 33-bit partial-remainder subtraction.
  - On the iteration with cnt==31, or the first multiply iteration when MUL_FAST=1:
    - Apply sign correction.
    - Write hi/lo at that edge.
    - Go to DONE.
- DONE:
  - mult_div_over=1 for exactly one cycle; go to IDLE.
  - start seen in DONE belongs to the completing instruction and is ignored.
- mult_div_stall is combinational: 1 when (state==IDLE && start && !flush) or state is MUL or DIV; 0 in DONE.
- mult_div_over is registered-state decoded: 1 iff state==DONE.
- Latency, with start first seen in IDLE at cycle T and no stalls:
  - MUL_FAST=0 or any divide: hi/lo written at the end of cycle T+32; over=1 in cycle T+33.
  - MUL_FAST=1 multiply: over=1 in T+2.
  - Each cpu_stall cycle adds one cycle.
- start is ignored in MUL, DIV and DONE. Operands are used only as latched in IDLE.
- Result mapping:
  - Multiply: {hi,lo} = 64-bit product; signed for MULT, unsigned for MULTU.
  - Divide: lo=quotient, hi=remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Boundary cases:
  - b==0 on a divide: lo=ZERO_DIV_Q, hi=a. Full iteration count still taken; no exception.
  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
  - Reset mid-operation: immediate return to IDLE with hi=lo=0.
  - flush in the same cycle as the completing iteration: no write, no pulse.
  - flush in DONE: pulse suppressed for that cycle; hi/lo keep the new result.

Test Plan:
- MULT a=32'hFFFFFFFE (-2), b=7, MUL_FAST=0 -> stall=1 T..T+32; over=1 only in T+33; hi=32'hFFFFFFFF, lo=32'hFFFFFFF2.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. With MUL_FAST=1, over arrives in T+2.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, over at T+33. DIV 32'h80000000/-1 -> lo=32'h80000000, hi=0.
- Timing stress:
  - cpu_stall high for 3 cycles mid-divide -> over moves to T+36.
  - start held through DONE -> no second operation; over pulses once.
- Cancel and reset:
  - flush at T+10 -> IDLE next cycle; hi/lo keep prior values; no over pulse.
  - reset at T+5 -> hi=lo=0; state IDLE.
